// File: rtl/mul4x4sign_pkg.sv
// Shared types and constants for the signed 4x4 sequential shift-add multiplier.
package mul4x4sign_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int N_STEPS = 4;
  localparam int ACC_W   = 8;
  localparam int CNT_W   = 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

  // Sign-extend a 5-bit add/sub result to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_acc(input logic [4:0] r);
    return {{(ACC_W-5){r[4]}}, r};
  endfunction

endpackage

// File: rtl/overlap_getter.sv
// Selects the 4-bit accumulator window sum_old[clk1+3:clk1] for the current step.
module overlap_getter
  import mul4x4sign_pkg::*;
(
  input  logic [ACC_W-1:0] sum_old,
  input  logic [CNT_W-1:0] clk1,
  output logic [3:0]       sum_old_part
);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_old_part = '0;
    case (clk1)
      2'd0:    sum_old_part = sum_old[3:0];
      2'd1:    sum_old_part = sum_old[4:1];
      2'd2:    sum_old_part = sum_old[5:2];
      2'd3:    sum_old_part = sum_old[6:3];
      default: sum_old_part = '0;
    endcase
  end

endmodule

// File: rtl/mul4x4sign_seq_ctrl.sv
// Sequential signed 4x4 multiplier: FSM, step counter, 8-bit accumulator and add/sub write-back.
module mul4x4sign_seq_ctrl
  import mul4x4sign_pkg::*;
#(
  parameter bit BACK2BACK = 1'b1,
  parameter int OPW       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] product
);

  if (OPW != 4) begin : g_opw_check
    $error("mul4x4sign_seq_ctrl: OPW must be 4 (window width is fixed)");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk1_q, clk1_d;
  logic [ACC_W-1:0] sum_old_q, sum_old_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] product_q, product_d;

  logic [3:0]       sum_old_part;
  logic [OPW:0]     p_ext, a_ext, r;
  logic [ACC_W-1:0] wb_mask, sum_wb;
  logic             accept;

  overlap_getter u_overlap_getter (
    .sum_old      (sum_old_q),
    .clk1         (clk1_q),
    .sum_old_part (sum_old_part)
  );

  assign ready   = (state_q == ST_IDLE) || (BACK2BACK && (state_q == ST_DONE));
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;
  assign accept  = start && ready;

  // Five-bit result keeps -8*-8's final step (0 - (-8) = +8) from wrapping.
  always_comb begin
    p_ext = {sum_old_part[3], sum_old_part};
    a_ext = {a_q[OPW-1], a_q};
    if (!b_q[clk1_q])             r = p_ext;
    else if (clk1_q == LAST_STEP) r = p_ext - a_ext;
    else                          r = p_ext + a_ext;
    // Bits below the current step are already final; only [7:i] is rewritten.
    wb_mask = {ACC_W{1'b1}} << clk1_q;
    sum_wb  = (sum_old_q & ~wb_mask) | ((sext_acc(r) << clk1_q) & wb_mask);
  end

  always_comb begin
    state_d   = state_q;
    clk1_d    = clk1_q;
    sum_old_d = sum_old_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        sum_old_d = sum_wb;
        clk1_d    = clk1_q + 1'b1;
        if (clk1_q == LAST_STEP) begin
          state_d   = ST_DONE;
          product_d = sum_wb;
        end
      end
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d       = a;
      b_d       = b;
      sum_old_d = '0;
      clk1_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk1_q    <= '0;
      sum_old_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      clk1_q    <= clk1_d;
      sum_old_q <= sum_old_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_mul4x4sign_seq_ctrl.sv
// Directed and exhaustive self-checking bench for mul4x4sign_seq_ctrl (both BACK2BACK settings).
module tb_mul4x4sign_seq_ctrl;

  logic       clk, rst_n, start;
  logic [3:0] a, b;
  logic       ready, busy, done;
  logic [7:0] product;
  logic       ready_nb, busy_nb, done_nb;
  logic [7:0] product_nb;

  int n_checks = 0;
  int n_errors = 0;

  mul4x4sign_seq_ctrl #(.BACK2BACK(1'b1), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  mul4x4sign_seq_ctrl #(.BACK2BACK(1'b0), .OPW(4)) dut_nb (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready_nb), .busy(busy_nb), .done(done_nb), .product(product_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with fixed-latency checks; operands are scrambled after accept.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp, input bit steps);
    int n;
    logic [7:0] mask;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_start", ready, 1);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    for (int k = 0; k < 4; k++) begin
      check("busy_run", busy, 1);
      check("done_low_run", done, 0);
      tick();
      if (steps && k < 3) begin
        mask = 8'((2 << k) - 1);
        check("sum_old_final_bits", dut.sum_old_q & mask, exp & mask);
      end
    end
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("product", product, exp);
    tick();
    check("done_one_cycle", done, 0);
    check("ready_after", ready, 1);
    check("product_hold", product, exp);
  endtask

  initial begin
    int pa, pb, n_done;
    int acc1[8];
    int acc0[8];
    int n1, n0;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 8'h00);
    check("rst_clk1", dut.clk1_q, 0);
    check("rst_ready_nb", ready_nb, 1);
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-computed products.
    run_op(4'h3, 4'hE, 8'hFA, 1'b1);
    run_op(4'h8, 4'h8, 8'h40, 1'b1);
    run_op(4'h8, 4'h7, 8'hC8, 1'b1);
    run_op(4'h7, 4'h7, 8'h31, 1'b1);
    run_op(4'h0, 4'hF, 8'h00, 1'b1);

    // start pulsed while busy must be ignored.
    a = 4'h3; b = 4'hE; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'h1; b = 4'h1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("busy_start_done", done, 1);
    check("busy_start_product", product, 8'hFA);
    tick();
    check("busy_start_no_accept", busy, 0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) n_done++;
      tick();
    end
    check("busy_start_no_extra_done", n_done, 0);

    // Asynchronous reset during RUN step 2.
    a = 4'h5; b = 4'h3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_clk1", dut.clk1_q, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_ready", ready, 1);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_product", product, 8'h00);
    check("midrun_rst_sum_old", dut.sum_old_q, 0);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) n_done++;
    end
    check("midrun_rst_no_done", n_done, 0);
    run_op(4'h5, 4'h3, 8'h0F, 1'b1);

    // start held high: throughput of both variants.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    a = 4'h2; b = 4'h3; start = 1'b1;
    n1 = 0;
    n0 = 0;
    for (int c = 0; c < 30; c++) begin
      if (ready && n1 < 8) begin
        if (n1 > 0) check("b2b_done_with_accept", done, 1);
        acc1[n1] = c;
        n1++;
      end
      if (ready_nb && n0 < 8) begin
        acc0[n0] = c;
        n0++;
      end
      tick();
    end
    start = 1'b0;
    check("b2b_accept_count", n1, 6);
    check("nb_accept_count", n0, 5);
    check("b2b_gap1", acc1[1] - acc1[0], 5);
    check("b2b_gap2", acc1[2] - acc1[1], 5);
    check("nb_gap1", acc0[1] - acc0[0], 6);
    check("nb_gap2", acc0[2] - acc0[1], 6);
    check("b2b_product", product, 8'h06);
    check("nb_product", product_nb, 8'h06);
    for (int c = 0; c < 8; c++) tick();

    // Exhaustive operand sweep against the signed reference product.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        pa = $signed(4'(ia));
        pb = $signed(4'(ib));
        run_op(4'(ia), 4'(ib), 8'(pa * pb), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
